picosoc_a2_mailbox: RTL

PICOSOC_A2_MAILBOX -- requirements
Module: picosoc_a2_mailbox

---
 rtl/picosoc_a2_mailbox.sv | 80 ++++++++
 1 files changed

// File: rtl/picosoc_a2_mailbox.sv
// picosoc_a2_mailbox: queues Apple II mailbox writes in a FIFO that PicoSoC firmware drains over iomem
module picosoc_a2_mailbox #(
    parameter int          DEPTH     = 8,
    parameter logic [15:0] CMD_ADDR  = 16'hC7FF,
    parameter logic [15:0] DATA_ADDR = 16'hC7FE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        iomem_ready,
    input  logic [15:0] a2_addr,
    input  logic [7:0]  a2_data,
    input  logic        a2_rw_n,
    input  logic        a2_data_in_strobe,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          overflow, irq_en, done;
    logic          accept, is_write, not_empty, full, push_req, pop, flush, ovf_clr, push_ok, ovf_set;
    logic [5:0]    sel;
    logic [31:0]   head_word, status_word, read_word;

    always_comb begin
        sel = iomem_addr[7:2];
        // done blocks a second acceptance while the master still holds valid after its ack
        accept = iomem_valid & ~iomem_ready & ~done;
        is_write = |iomem_wstrb;
        not_empty = count != '0;
        full = count == FULL_COUNT;
        push_req = a2_data_in_strobe & ~a2_rw_n & ((a2_addr == CMD_ADDR) | (a2_addr == DATA_ADDR));
        pop = accept & ~is_write & (sel == 6'd1) & not_empty;
        flush = accept & is_write & (sel == 6'd0) & iomem_wdata[0];
        ovf_clr = accept & is_write & (sel == 6'd0) & iomem_wdata[2];
        push_ok = push_req & ~flush & (~full | pop);
        ovf_set = push_req & ~flush & full & ~pop;
        head_word = not_empty ? {1'b1, 22'b0, mem[rd_ptr]} : '0;
        status_word = {16'b0, 8'(count), 5'b0, overflow, full, not_empty};
        read_word = is_write ? '0 :
                    (sel == 6'd0) ? status_word :
                    ((sel == 6'd1) | (sel == 6'd2)) ? head_word :
                    (sel == 6'd3) ? {31'b0, irq_en} : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
            irq_en <= 1'b0;
            irq <= 1'b0;
            done <= 1'b0;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else begin
            iomem_ready <= accept;
            iomem_rdata <= accept ? read_word : '0;
            done <= iomem_valid & (iomem_ready | done);
            irq <= irq_en & not_empty;
            overflow <= (overflow & ~ovf_clr) | ovf_set;
            if (accept & is_write & (sel == 6'd3)) irq_en <= iomem_wdata[0];
            rd_ptr <= flush ? '0 : pop ? rd_ptr + AW'(1) : rd_ptr;
            wr_ptr <= flush ? '0 : push_ok ? wr_ptr + AW'(1) : wr_ptr;
            count <= flush ? '0 : count + (AW+1)'(push_ok) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok & ~reset) mem[wr_ptr] <= {a2_addr == CMD_ADDR, a2_data};
    end
endmodule
